// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store data memory.
//   - RV32I load/store funct3 encodings
//   - FSM state type for the access sequencer
//   - legality check for a funct3 given load/store direction
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Stores accept only B/H/W; loads additionally accept the unsigned forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we && ((f3 == F3_BU) || (f3 == F3_HU))) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering for 32-bit sub-word accesses.
// Ports:
//   funct3_i   - load/store funct3
//   addr_lo_i  - byte offset within the word (addr[1:0])
//   wdata_i    - right-aligned store data
//   rword_i    - full memory word being read
//   be_o       - store byte enables
//   wdata_o    - store data replicated onto every lane
//   rdata_o    - selected load lane, sign- or zero-extended
module byte_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Size is carried in funct3[1:0]; replicating the data means the byte
    // enables alone pick the destination lane.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rword_i >> {addr_lo_i, 3'b000};

    always_comb begin
        rdata_o = rword_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Handshaked data memory with RV32I sub-word loads/stores and a fixed
// configurable access latency.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_we              - 1 = store, 0 = load
//   req_funct3          - RV32I load/store funct3
//   req_addr            - byte address
//   req_wdata           - right-aligned store data
//   rsp_valid           - one-cycle response strobe
//   rsp_rdata           - extended load data, 0 for stores and errors
//   rsp_err             - misaligned / out of range / illegal funct3
//   busy                - sequencer not idle
module lsu_data_memory
    import riscv_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic              accept, enter_resp;
    logic              cur_we;
    logic [2:0]        cur_f3;
    logic [XLEN-1:0]   cur_addr, cur_wdata;
    logic              misaligned, out_of_range, acc_err;
    logic [AW-1:0]     word_idx;
    logic [3:0]        be;
    logic [XLEN-1:0]   wrep, ldata;

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) state_d = WAIT;
                    else             state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) state_d = RESP;
                else                   cnt_d   = cnt_q + 3'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_q != RESP) && (state_d == RESP);

    // With zero latency the access completes on the accept edge, before the
    // capture registers hold the request, so the live inputs are used then.
    assign cur_we    = accept ? req_we     : we_q;
    assign cur_f3    = accept ? req_funct3 : f3_q;
    assign cur_addr  = accept ? req_addr   : addr_q;
    assign cur_wdata = accept ? req_wdata  : wdata_q;

    assign misaligned   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                          ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    // Any set bit above the word index means the word is beyond DEPTH_WORDS.
    assign out_of_range = |cur_addr[XLEN-1:AW+2];
    assign acc_err      = !f3_legal(cur_we, cur_f3) || misaligned || out_of_range;
    assign word_idx     = cur_addr[AW+1:2];

    byte_lane_align u_align (
        .funct3_i  (cur_f3),
        .addr_lo_i (cur_addr[1:0]),
        .wdata_i   (cur_wdata),
        .rword_i   (mem_q[word_idx]),
        .be_o      (be),
        .wdata_o   (wrep),
        .rdata_o   (ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || cur_we) ? '0 : ldata;
            end
        end
    end

    // Array is never cleared; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[word_idx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_data_memory.sv
module tb_lsu_data_memory;
    import riscv_mem_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 64;
    localparam int LATS [N] = '{1, 0, 7, 3};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset      [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_we     [N];
    logic [2:0]  req_funct3 [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic        rsp_valid  [N];
    logic [31:0] rsp_rdata  [N];
    logic        rsp_err    [N];
    logic        busy       [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        lsu_data_memory #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(LATS[g])) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .busy       (busy[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memory per instance.
    logic [7:0] mdl [N][DEPTH*4];

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] exp_rd;
        bit        exp_er;
    } vec_t;

    task automatic model(input int d, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, output bit [31:0] rd, output bit er);
        int size;
        bit legal;
        bit [31:0] v;
        legal = 1'b1;
        size  = 1;
        case (f3)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        er = !legal || ((addr % size) != 0) || ((addr / 4) >= DEPTH);
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[d][addr + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[d][addr + i];
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endtask

    // Issues one request and reports what came back: lat is the number of
    // falling edges after the accept edge until rsp_valid (-1 on timeout).
    task automatic do_access(input int d, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wd, output int lat, output bit [31:0] rd,
                             output bit er, output bit rdy_low, output bit rdy_back);
        int w;
        lat = -1; rd = 32'h0; er = 1'b0; rdy_low = 1'b1; rdy_back = 1'b0;
        @(negedge clk);
        w = 0;
        while (!req_ready[d] && w < 30) begin
            @(negedge clk);
            w++;
        end
        req_we[d] = we; req_funct3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (req_ready[d]) rdy_low = 1'b0;
            if (rsp_valid[d]) begin
                lat = n; rd = rsp_rdata[d]; er = rsp_err[d];
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rdy_back = req_ready[d] && !rsp_valid[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_funct3[d] = 3'd0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({req_ready[d], busy[d], rsp_valid[d], rsp_err[d]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d: got rdy/busy/vld/err=%b want 1000", d,
                         {req_ready[d], busy[d], rsp_valid[d], rsp_err[d]});
            end
            checks++;
            if (rsp_rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata dut%0d: got %h want 00000000", d, rsp_rdata[d]);
            end
            reset[d] = 1'b0;
        end
    endtask

    task automatic run_table(input string name, input vec_t t[$]);
        int lat; bit [31:0] rd; bit er, rl, rb;
        foreach (t[i]) begin
            do_access(0, t[i].we, t[i].f3, t[i].addr, t[i].wd, lat, rd, er, rl, rb);
            checks++;
            if (rd !== t[i].exp_rd || er !== t[i].exp_er) begin
                errors++;
                $display("FAIL %s[%0d]: got rdata=%h err=%b want rdata=%h err=%b",
                         name, i, rd, er, t[i].exp_rd, t[i].exp_er);
            end
            checks++;
            if (lat !== LATS[0] + 1 || {rl, rb} !== 2'b11) begin
                errors++;
                $display("FAIL %s_timing[%0d]: got lat=%0d ready_low=%b ready_back=%b want lat=%0d 1 1",
                         name, i, lat, rl, rb, LATS[0] + 1);
            end
        end
    endtask

    task automatic test_subword();
        vec_t t[$];
        t.push_back('{1'b1, F3_W,  32'h10, 32'h1234_5678, 32'h0000_0000, 1'b0});
        t.push_back('{1'b0, F3_W,  32'h10, 32'h0,         32'h1234_5678, 1'b0});
        t.push_back('{1'b1, F3_B,  32'h11, 32'h5A5A_5AAB, 32'h0000_0000, 1'b0});
        t.push_back('{1'b0, F3_B,  32'h11, 32'h0,         32'hFFFF_FFAB, 1'b0});
        t.push_back('{1'b0, F3_BU, 32'h11, 32'h0,         32'h0000_00AB, 1'b0});
        t.push_back('{1'b0, F3_W,  32'h10, 32'h0,         32'h1234_AB78, 1'b0});
        t.push_back('{1'b1, F3_H,  32'h12, 32'hCDEF_8001, 32'h0000_0000, 1'b0});
        t.push_back('{1'b0, F3_H,  32'h12, 32'h0,         32'hFFFF_8001, 1'b0});
        t.push_back('{1'b0, F3_HU, 32'h12, 32'h0,         32'h0000_8001, 1'b0});
        t.push_back('{1'b0, F3_W,  32'h10, 32'h0,         32'h8001_AB78, 1'b0});
        t.push_back('{1'b0, F3_H,  32'h10, 32'h0,         32'hFFFF_AB78, 1'b0});
        t.push_back('{1'b0, F3_B,  32'h10, 32'h0,         32'h0000_0078, 1'b0});
        run_table("subword", t);
    endtask

    task automatic test_errors();
        vec_t t[$];
        t.push_back('{1'b0, F3_W,  32'h12,      32'h0,         32'h0, 1'b1});
        t.push_back('{1'b1, F3_H,  32'h13,      32'h0000_FFFF, 32'h0, 1'b1});
        t.push_back('{1'b1, 3'b011, 32'h10,     32'hDEAD_BEEF, 32'h0, 1'b1});
        t.push_back('{1'b0, 3'b011, 32'h10,     32'h0,         32'h0, 1'b1});
        t.push_back('{1'b1, F3_BU, 32'h10,      32'h0000_00EE, 32'h0, 1'b1});
        t.push_back('{1'b0, F3_W,  DEPTH * 4,   32'h0,         32'h0, 1'b1});
        t.push_back('{1'b1, F3_W,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b1});
        t.push_back('{1'b0, F3_W,  32'h10,      32'h0,         32'h8001_AB78, 1'b0});
        run_table("errors", t);
    endtask

    task automatic test_latency();
        int lat; bit [31:0] rd, v; bit er, rl, rb;
        for (int d = 1; d <= 2; d++) begin
            v = $urandom;
            do_access(d, 1'b1, F3_W, 32'h40, v, lat, rd, er, rl, rb);
            checks++;
            if (lat !== LATS[d] + 1 || er !== 1'b0 || {rl, rb} !== 2'b11) begin
                errors++;
                $display("FAIL lat_store dut%0d: got lat=%0d err=%b rdy=%b%b want lat=%0d err=0 rdy=11",
                         d, lat, er, rl, rb, LATS[d] + 1);
            end
            do_access(d, 1'b0, F3_W, 32'h40, 32'h0, lat, rd, er, rl, rb);
            checks++;
            if (lat !== LATS[d] + 1 || rd !== v || {rl, rb} !== 2'b11) begin
                errors++;
                $display("FAIL lat_load dut%0d: got lat=%0d rdata=%h rdy=%b%b want lat=%0d rdata=%h rdy=11",
                         d, lat, rd, rl, rb, LATS[d] + 1, v);
            end
        end
    endtask

    // req_valid held high: accepts land every LATENCY+2 edges, so responses
    // appear at samples L+1, 2L+3, 3L+5 within a 3*(L+2) window.
    task automatic test_back_to_back();
        int l, pulses, bad, w;
        for (int d = 0; d <= 2; d++) begin
            l = LATS[d];
            pulses = 0; bad = 0;
            @(negedge clk);
            req_we[d] = 1'b0; req_funct3[d] = F3_W; req_addr[d] = 32'h10; req_valid[d] = 1'b1;
            for (int n = 1; n <= 3 * (l + 2); n++) begin
                @(negedge clk);
                if (rsp_valid[d]) pulses++;
                if (rsp_valid[d] !== ((n >= l + 1) && ((n - (l + 1)) % (l + 2) == 0))) bad++;
            end
            req_valid[d] = 1'b0;
            w = 0;
            while (busy[d] && w < 20) begin
                @(negedge clk);
                if (rsp_valid[d]) pulses++;
                w++;
            end
            checks++;
            if (pulses !== 3 || bad !== 0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL b2b dut%0d: got pulses=%0d misplaced=%0d busy=%b want pulses=3 misplaced=0 busy=0",
                         d, pulses, bad, busy[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, seen; bit [31:0] rd; bit er, rl, rb;
        do_access(3, 1'b1, F3_W, 32'h20, 32'hCAFE_F00D, lat, rd, er, rl, rb);
        checks++;
        if (lat !== LATS[3] + 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_store: got lat=%0d err=%b want lat=%0d err=0", lat, er, LATS[3] + 1);
        end
        @(negedge clk);
        req_we[3] = 1'b1; req_funct3[3] = F3_W; req_addr[3] = 32'h20;
        req_wdata[3] = 32'h1111_1111; req_valid[3] = 1'b1;
        @(negedge clk);
        req_valid[3] = 1'b0;
        seen = rsp_valid[3] ? 1 : 0;
        reset[3] = 1'b1;
        @(negedge clk);
        reset[3] = 1'b0;
        checks++;
        if ({req_ready[3], busy[3]} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_idle: got ready/busy=%b want 10", {req_ready[3], busy[3]});
        end
        for (int n = 0; n < 12; n++) begin
            if (rsp_valid[3]) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_norsp: got %0d responses want 0", seen);
        end
        do_access(3, 1'b0, F3_W, 32'h20, 32'h0, lat, rd, er, rl, rb);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_keep: got rdata=%h err=%b want cafef00d err=0", rd, er);
        end
    endtask

    task automatic test_random();
        int lat; bit [31:0] rd, erd, addr, wd; bit er, eer, rl, rb, we; bit [2:0] f3;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            model(0, 1'b1, F3_W, 32'(w * 4), wd, erd, eer);
            do_access(0, 1'b1, F3_W, 32'(w * 4), wd, lat, rd, er, rl, rb);
            checks++;
            if (er !== eer || rd !== erd || lat !== LATS[0] + 1) begin
                errors++;
                $display("FAIL fill[%0d]: got rdata=%h err=%b lat=%0d want %h %b %0d",
                         w, rd, er, lat, erd, eer, LATS[0] + 1);
            end
        end
        for (int i = 0; i < 150; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
            wd   = $urandom;
            model(0, we, f3, addr, wd, erd, eer);
            do_access(0, we, f3, addr, wd, lat, rd, er, rl, rb);
            checks++;
            if (rd !== erd || er !== eer || lat !== LATS[0] + 1 || {rl, rb} !== 2'b11) begin
                errors++;
                $display("FAIL rand[%0d] we=%b f3=%0d addr=%h: got rdata=%h err=%b lat=%0d want %h %b %0d",
                         i, we, f3, addr, rd, er, lat, erd, eer, LATS[0] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_errors();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
